mips_cpu_muldiv: RTL and testbench

Iterative multiply/divide unit owning the architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage and takes over MULT/MULTU/DIV/DIVU so that these no longer form long combinational paths. It also services MTHI/MTLO writes. The control unit stalls the pipeline on busy and reads hi/lo for MFHI/MFLO.

---
 rtl/mips_cpu_muldiv_if.sv | 25 ++
 rtl/mips_cpu_muldiv.sv | 168 ++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface mips_cpu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring shift-subtract on
// operand magnitudes; a final FIX cycle applies signs and writes HI/LO.
module mips_cpu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    mips_cpu_muldiv_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [4:0] OpDiv   = 5'd9;
    localparam logic [4:0] OpDivu  = 5'd10;
    localparam logic [4:0] OpMult  = 5'd11;
    localparam logic [4:0] OpMultu = 5'd12;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // MUL: {partial product high half, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_q, a_d;           // original dividend for divide-by-zero
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               bzero_q, bzero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               op_valid, op_signed, op_is_div, accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_valid  = (bus.op == OpDiv) || (bus.op == OpDivu) ||
                       (bus.op == OpMult) || (bus.op == OpMultu);
    assign op_signed = (bus.op == OpDiv) || (bus.op == OpMult);
    assign op_is_div = (bus.op == OpDiv) || (bus.op == OpDivu);
    assign accept    = (state_q == StIdle) && bus.start && op_valid;

    // Two's-complement negation of -2^(WIDTH-1) gives 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned, so WIDTH bits suffice here.
    assign a_neg = op_signed && bus.a[WIDTH-1];
    assign b_neg = op_signed && bus.b[WIDTH-1];
    assign mag_a = a_neg ? -bus.a : bus.a;
    assign mag_b = b_neg ? -bus.b : bus.b;

    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so a set MSB of the difference means
    // the trial subtraction underflowed and the shifted remainder is kept.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, mcand_q};
    assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = res_neg_q ? -acc_q : acc_q;
    assign quo_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state: accept/MTHI/MTLO in idle, iterate, then sign-fix and write HI/LO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = op_is_div ? StDiv : StMul;
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}}, op_is_div ? mag_a : mag_b};
                    mcand_d   = op_is_div ? mag_b : mag_a;
                    a_d       = bus.a;
                    is_div_d  = op_is_div;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    bzero_d   = (bus.b == '0);
                end else begin
                    if (bus.mthi) hi_d = bus.a;
                    if (bus.mtlo) lo_d = bus.a;
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) state_d = StFix;
            end
            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: a transaction-level model of HI/LO,
// busy and done compared every cycle, plus literal expectations per operation.
module tb_mips_cpu_muldiv;
    localparam int unsigned W = 32;
    localparam int Latency = W + 1;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mips_cpu_muldiv_if #(.WIDTH(W)) bus ();

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] model_op(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0]        ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            5'd11: return sa * sb;
            5'd12: return ua * ub;
            5'd9: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            5'd10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: an accepted op publishes its result Latency edges later.
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem   <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
            m_done  <= 1'b0;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_hi <= pend_hi;
                m_lo <= pend_lo;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start && bus.op >= 5'd9 && bus.op <= 5'd12) begin
                {pend_hi, pend_lo} <= model_op(bus.op, bus.a, bus.b);
                m_rem <= Latency;
            end else begin
                if (bus.mthi) m_hi <= bus.a;
                if (bus.mtlo) m_lo <= bus.a;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        check("busy", {63'd0, bus.busy}, {63'd0, m_rem != 0});
        check("done", {63'd0, bus.done}, {63'd0, m_done});
        check("hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("lo", {32'd0, bus.lo}, {32'd0, m_lo});
    end

    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Returns at the negedge where done is seen, counting busy cycles on the way.
    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    int n;

    initial begin
        bus.start = 1'b0;
        bus.op    = 5'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hi", {32'd0, bus.hi}, 64'd0);
        check("reset_lo", {32'd0, bus.lo}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // MULTU all ones
        start_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        check("multu_busy_cycles", 64'(n), 64'd33);
        check("multu_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        check("multu_lo", {32'd0, bus.lo}, 64'h0000_0000_0000_0001);
        @(negedge clk);
        check("multu_done_pulse", {63'd0, bus.done}, 64'd0);

        // MULT -3 * 5, old HI/LO visible mid-operation
        start_op(5'd11, 32'hFFFF_FFFD, 32'd5);
        repeat (5) @(negedge clk);
        check("mult_old_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        check("mult_old_lo", {32'd0, bus.lo}, 64'h0000_0000_0000_0001);
        wait_done(n);
        check("mult_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFF1);

        // DIV -7 / 2, then back-to-back ops issued in the done cycle
        start_op(5'd9, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        check("div_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
        start_op(5'd10, 32'd100, 32'd7);
        wait_done(n);
        check("divu_busy_cycles", 64'(n), 64'd33);
        check("divu_lo", {32'd0, bus.lo}, 64'd14);
        check("divu_hi", {32'd0, bus.hi}, 64'd2);
        start_op(5'd9, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        check("div_ovf_lo", {32'd0, bus.lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_hi", {32'd0, bus.hi}, 64'd0);

        // Divide by zero
        start_op(5'd10, 32'd5, 32'd0);
        wait_done(n);
        check("divz_busy_cycles", 64'(n), 64'd33);
        check("divz_hi", {32'd0, bus.hi}, 64'd5);
        check("divz_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFF);
        start_op(5'd9, 32'hFFFF_FFF0, 32'd0);
        wait_done(n);
        check("divz_s_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFF0);
        check("divz_s_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFF);

        // start and mthi while busy are ignored
        start_op(5'd12, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 5'd12;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.mthi  = 1'b1;
        bus.a     = 32'h1234;
        @(posedge clk);
        #2;
        bus.mthi  = 1'b0;
        wait_done(n);
        check("busy_start_lo", {32'd0, bus.lo}, 64'd12);
        check("busy_start_hi", {32'd0, bus.hi}, 64'd0);
        @(negedge clk);
        check("no_requeue_busy", {63'd0, bus.busy}, 64'd0);

        // mthi + mtlo in idle
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.a    = 32'hABCD;
        @(posedge clk);
        #2;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        @(negedge clk);
        check("mt_hi", {32'd0, bus.hi}, 64'h0000_0000_0000_ABCD);
        check("mt_lo", {32'd0, bus.lo}, 64'h0000_0000_0000_ABCD);

        // Start with a non-muldiv op does nothing
        start_op(5'd2, 32'd1, 32'd1);
        @(negedge clk);
        check("badop_busy", {63'd0, bus.busy}, 64'd0);
        repeat (3) @(negedge clk);
        check("badop_hi", {32'd0, bus.hi}, 64'h0000_0000_0000_ABCD);

        // Asynchronous reset in the middle of a DIV
        start_op(5'd9, 32'd1000, 32'd7);
        repeat (14) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_hi", {32'd0, bus.hi}, 64'd0);
        check("arst_lo", {32'd0, bus.lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_op(5'd10, 32'd1000, 32'd7);
        wait_done(n);
        check("post_rst_busy_cycles", 64'(n), 64'd33);
        check("post_rst_lo", {32'd0, bus.lo}, 64'd142);
        check("post_rst_hi", {32'd0, bus.hi}, 64'd6);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
